// File: rtl/grad_pkg.sv
// Shared types and constants for the gradient magnitude/direction stage.
package grad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateType;

  // Quantized gradient directions
  localparam logic [1:0] DIR_0   = 2'd0;
  localparam logic [1:0] DIR_45  = 2'd1;
  localparam logic [1:0] DIR_90  = 2'd2;
  localparam logic [1:0] DIR_135 = 2'd3;

  // tan(22.5 deg) ~= TAN_NUM / 2^TAN_SHIFT = 53/128
  localparam int TAN_NUM_DEF   = 53;
  localparam int TAN_SHIFT_DEF = 7;

endpackage

// File: rtl/grad_pixel.sv
// Combinational single-pixel unit: L1 gradient magnitude and 4-way
// direction quantization using a fixed-point tan(22.5 deg) threshold.
module grad_pixel
  import grad_pkg::*;
#(
  parameter int DATA_W    = 9,
  parameter int MAG_W     = 10,
  parameter int TAN_NUM   = TAN_NUM_DEF,
  parameter int TAN_SHIFT = TAN_SHIFT_DEF
) (
  input  logic signed [DATA_W-1:0] gx,
  input  logic signed [DATA_W-1:0] gy,
  output logic        [MAG_W-1:0]  mag,
  output logic        [1:0]        dir
);

  // Wide enough for |g| * TAN_NUM and |g| << TAN_SHIFT (TAN_NUM < 2^TAN_SHIFT)
  localparam int PW = DATA_W + TAN_SHIFT + 1;

  // Absolute value as an unsigned DATA_W result; the most negative input
  // maps to 2^(DATA_W-1), which still fits unsigned.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] u;
    u = v;
    return v[DATA_W-1] ? (~u + DATA_W'(1)) : u;
  endfunction

  // Sum of two magnitudes, zero-extended into the output width
  function automatic logic [MAG_W-1:0] sum_mag(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return MAG_W'(a) + MAG_W'(b);
  endfunction

  logic [DATA_W-1:0] ax;
  logic [DATA_W-1:0] ay;
  logic [PW-1:0]     ax_sh;
  logic [PW-1:0]     ay_sh;
  logic [PW-1:0]     ax_t;
  logic [PW-1:0]     ay_t;

  assign ax    = abs_val(gx);
  assign ay    = abs_val(gy);
  assign ax_sh = PW'(ax) << TAN_SHIFT;
  assign ay_sh = PW'(ay) << TAN_SHIFT;
  assign ax_t  = PW'(ax) * PW'(TAN_NUM);
  assign ay_t  = PW'(ay) * PW'(TAN_NUM);
  assign mag   = sum_mag(ax, ay);

  // Direction decision in priority order: near-horizontal, near-vertical,
  // then the diagonal picked by whether the gradient signs agree.
  always_comb begin
    dir = DIR_0;
    if (ay_sh <= ax_t)
      dir = DIR_0;
    else if (ay_t >= ax_sh)
      dir = DIR_90;
    else if (gx[DATA_W-1] == gy[DATA_W-1])
      dir = DIR_45;
    else
      dir = DIR_135;
  end

endmodule

// File: rtl/grad_mag_dir.sv
// Gradient magnitude/direction stage after the Sobel filter. On a rising
// sobel_done it snapshots the 4x4 gx/gy tiles, then walks the 16 pixels
// one per cycle through a single shared grad_pixel unit.
module grad_mag_dir
  import grad_pkg::*;
#(
  parameter int DATA_W    = 9,
  parameter int MAG_W     = 10,
  parameter int TAN_NUM   = TAN_NUM_DEF,
  parameter int TAN_SHIFT = TAN_SHIFT_DEF
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              sobel_done,
  input  logic [3:0][3:0][DATA_W-1:0]       data_x,
  input  logic [3:0][3:0][DATA_W-1:0]       data_y,
  output logic [3:0][3:0][MAG_W-1:0]        grad_mag,
  output logic [3:0][3:0][1:0]              grad_dir,
  output logic                              grad_busy,
  output logic                              grad_done
);

  stateType                      state;
  logic [3:0]                    idx;
  logic                          sobel_done_q;
  logic [3:0][3:0][DATA_W-1:0]   gx_cap;
  logic [3:0][3:0][DATA_W-1:0]   gy_cap;
  logic                          start;
  logic signed [DATA_W-1:0]      pix_gx;
  logic signed [DATA_W-1:0]      pix_gy;
  logic [MAG_W-1:0]              pix_mag;
  logic [1:0]                    pix_dir;

  // Only a low-to-high transition of the level flag starts a tile
  assign start  = sobel_done & ~sobel_done_q;
  assign pix_gx = gx_cap[idx[3:2]][idx[1:0]];
  assign pix_gy = gy_cap[idx[3:2]][idx[1:0]];

  grad_pixel #(
    .DATA_W    (DATA_W),
    .MAG_W     (MAG_W),
    .TAN_NUM   (TAN_NUM),
    .TAN_SHIFT (TAN_SHIFT)
  ) u_pixel (
    .gx  (pix_gx),
    .gy  (pix_gy),
    .mag (pix_mag),
    .dir (pix_dir)
  );

  // Edge detector, tile capture, pixel sequencer and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      idx          <= '0;
      sobel_done_q <= 1'b0;
      gx_cap       <= '0;
      gy_cap       <= '0;
      grad_mag     <= '0;
      grad_dir     <= '0;
      grad_busy    <= 1'b0;
      grad_done    <= 1'b0;
    end else begin
      sobel_done_q <= sobel_done;
      case (state)
        IDLE: begin
          grad_done <= 1'b0;
          if (start) begin
            gx_cap    <= data_x;
            gy_cap    <= data_y;
            idx       <= '0;
            grad_busy <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          grad_mag[idx[3:2]][idx[1:0]] <= pix_mag;
          grad_dir[idx[3:2]][idx[1:0]] <= pix_dir;
          idx <= idx + 4'd1;
          if (idx == 4'd15) begin
            grad_busy <= 1'b0;
            grad_done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          grad_done <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          grad_busy <= 1'b0;
          grad_done <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/grad_mag_dir.md
Name: grad_mag_dir

Overview:
- Stage directly downstream of the Sobel filter in the edge-detection pipeline.
- Consumes the 4x4 horizontal (gx) and vertical (gy) gradient tiles plus the Sobel done flag.
- Produces, one pixel per cycle, a gradient magnitude (|gx|+|gy|) and a 2-bit quantized direction for each of the 16 pixels.
- Results feed the non-maximum-suppression stage.

Parameters:
- DATA_W, 9: width of each signed two's-complement gradient input.
- MAG_W, 10: width of each magnitude output. Must be at least DATA_W+1.
- TAN_NUM, 53: numerator of the tan(22.5 deg) approximation, TAN_NUM / 2^TAN_SHIFT.
- TAN_SHIFT, 7: shift of the tan approximation. 53/128 = 0.414.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- sobel_done  in  1  Sobel done flag. Level signal that may stay high for many cycles.
- data_x  in  [3:0][3:0][DATA_W-1:0]  gx tile, signed.
- data_y  in  [3:0][3:0][DATA_W-1:0]  gy tile, signed.
- grad_mag  out  [3:0][3:0][MAG_W-1:0]  magnitude tile, registered.
- grad_dir  out  [3:0][3:0][1:0]  direction tile, registered. 0=0deg, 1=45deg, 2=90deg, 3=135deg.
- grad_busy  out  1  high while in the CALC state.
- grad_done  out  1  one-cycle pulse when the tile is complete.

Behaviour:
- Reset: the following clear to 0 asynchronously:
  - state goes to IDLE
  - pixel index idx, sobel_done_q, and the internal gx/gy capture registers
  - grad_mag, grad_dir, grad_busy, grad_done
- Start condition:
  - start = sobel_done & ~sobel_done_q, where sobel_done_q is sobel_done registered every cycle.
  - A start is accepted only in IDLE. A start seen in CALC or DONE is dropped, not queued.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On start at edge E0: capture data_x/data_y into the internal registers, set idx=0, go to CALC, set grad_busy=1.
  - Upstream may change data_x/data_y after E0 without effect.
- CALC:
  - Each edge processes pixel idx from the captured copy: row = idx[3:2], col = idx[1:0].
  - Writes grad_mag[row][col] and grad_dir[row][col], then increments idx.
  - Pixels 0..15 are written at edges E0+1 .. E0+16.
  - At E0+16: state goes to DONE, grad_busy=0, grad_done=1.
- DONE:
  - At the next edge (E0+17): grad_done=0, state goes to IDLE.
  - grad_done is high for exactly one cycle, 16 cycles after the start edge.
- Outputs:
  - Untouched pixels hold their previous values during CALC.
  - The full tile is valid from E0+16 until the next start.
- Arithmetic (per pixel):
  - ax = |gx|, ay = |gy|, each unsigned DATA_W bits. |-256| = 256 fits in 9 bits unsigned.
  - mag = ax + ay, zero-extended to MAG_W bits. Maximum 512, no saturation needed at defaults.
  - Sign: sx = gx MSB, sy = gy MSB. Zero counts as positive.
- Direction, evaluated in this priority order, with full-width products and no truncation:
  1. If (ay << TAN_SHIFT) <= ax*TAN_NUM, dir = 0.
  2. Else if ay*TAN_NUM >= (ax << TAN_SHIFT), dir = 2.
  3. Else if sx == sy, dir = 1.
  4. Else dir = 3.
  - gx = gy = 0 gives mag 0, dir 0.
- Reset mid-CALC: everything clears immediately. No grad_done pulse. The next start begins a fresh tile.
- sobel_done held high through the end of a tile: no restart. A low-then-high transition is required.

Decomposition:
- Package grad_pkg:
  - stateType enum (IDLE, CALC, DONE)
  - direction localparams DIR_0, DIR_45, DIR_90, DIR_135
  - default TAN_NUM / TAN_SHIFT values
- Sub-module grad_pixel: combinational single-pixel unit.
  - Inputs: gx, gy.
  - Outputs: mag, dir.
  - Instantiated once and time-multiplexed by idx.

Test Plan:
1. Reset check: assert n_rst=0 mid-cycle, then release. All outputs are 0 and the state is IDLE. With sobel_done=0 for 20 cycles, grad_done stays 0.
2. All gx=+10, gy=0 (9'h00A, 9'h000); raise sobel_done at E0. grad_busy is high E0..E0+15, grad_done pulses for exactly one cycle after E0+16, every mag=10 and dir=0. A second tile with gx=0, gy=-20 (9'h1EC) gives mag=20, dir=2.
3. Diagonals and extremes:
   - gx=+30, gy=+30: mag 60, dir 1.
   - gx=+30, gy=-30: mag 60, dir 3.
   - gx=gy=-256 (9'h100): mag 512, dir 1.
   - gx=-1, gy=+255: mag 256, dir 2.
4. Threshold boundary:
   - gx=128, gy=53 (equality): dir 0.
   - gx=128, gy=54: dir 1.
   - gx=53, gy=128 (equality): dir 2.
   - Mixed per-pixel values verify the idx-to-(row,col) mapping, e.g. pixel [2][1] only gets gx=7 and reads back mag=7.
5. Hold sobel_done high for 40 cycles: exactly one grad_done pulse. Toggle sobel_done low then high at E0+5: ignored, no second run. Change data_x at E0+3: results reflect the values captured at E0.
6. Pull n_rst low at E0+8 (pixel 7 in flight): all outputs are 0 and there is no grad_done. A fresh start then completes normally with correct values.
